// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the ID-stage hazard unit and the
// pipeline registers it steers.
interface hazard_ctrl_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
);
  logic [REG_ADDR_WIDTH-1:0] id_rs1;
  logic [REG_ADDR_WIDTH-1:0] id_rs2;
  logic                      id_uses_rs1;
  logic                      id_uses_rs2;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic                      ex_is_load;
  logic                      ex_reg_write_en;
  logic                      branch_taken;
  logic                      dmem_busy;
  logic                      cnt_clr;

  logic                      pc_write_en;
  logic                      if_id_write_en;
  logic                      if_id_flush;
  logic                      ctr_sel;
  logic                      id_ex_write_en;
  logic                      ex_mem_hold;
  logic                      flush_busy;
  logic [CNT_WIDTH-1:0]      stall_cnt;
  logic [CNT_WIDTH-1:0]      flush_cnt;
  logic [CNT_WIDTH-1:0]      freeze_cnt;

  modport master (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    input  ex_rd, ex_is_load, ex_reg_write_en,
    input  branch_taken, dmem_busy, cnt_clr,
    output pc_write_en, if_id_write_en, if_id_flush,
    output ctr_sel, id_ex_write_en, ex_mem_hold,
    output flush_busy, stall_cnt, flush_cnt, freeze_cnt
  );

  modport slave (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    output ex_rd, ex_is_load, ex_reg_write_en,
    output branch_taken, dmem_busy, cnt_clr,
    input  pc_write_en, if_id_write_en, if_id_flush,
    input  ctr_sel, id_ex_write_en, ex_mem_hold,
    input  flush_busy, stall_cnt, flush_cnt, freeze_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// ID-stage hazard unit: load-use bubbles, branch flush sequencing,
// dmem freeze and saturating event counters.
module hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FLUSH_CYCLES   = 2,
  parameter int CNT_WIDTH      = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  hazard_ctrl_if.master bus
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  localparam logic [3:0] FC_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam bit         MULTI     = FLUSH_CYCLES > 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [0:0] state_q, state_d;
  logic [3:0] fc_q, fc_d;

  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_WIDTH-1:0] freeze_cnt_q, freeze_cnt_d;

  logic rs1_hit, rs2_hit, load_use;
  logic ev_freeze, ev_flush, ev_branch, ev_stall;
  logic pc_we, ifid_we, ifid_flush, csel, idex_we, hold, fbusy;

  assign rs1_hit = bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd);
  assign rs2_hit = bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd);

  // x0 is never a real producer, so it cannot create a hazard
  assign load_use = bus.ex_is_load && bus.ex_reg_write_en &&
                    (bus.ex_rd != '0) && (rs1_hit || rs2_hit);

  // Mutually exclusive events encode freeze > branch > load-use
  assign ev_freeze = bus.dmem_busy;
  assign ev_flush  = !bus.dmem_busy && (state_q == FLUSH);
  assign ev_branch = !bus.dmem_busy && (state_q == RUN) &&
                     bus.branch_taken;
  assign ev_stall  = !bus.dmem_busy && (state_q == RUN) &&
                     !bus.branch_taken && load_use;

  always_comb begin
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    ifid_flush = 1'b0;
    csel       = 1'b1;
    idex_we    = 1'b1;
    hold       = 1'b0;
    fbusy      = 1'b0;
    state_d    = state_q;
    fc_d       = fc_q;
    unique case (1'b1)
      ev_freeze: begin
        pc_we   = 1'b0;
        ifid_we = 1'b0;
        idex_we = 1'b0;
        hold    = 1'b1;
      end
      ev_flush: begin
        ifid_flush = 1'b1;
        csel       = 1'b0;
        fbusy      = 1'b1;
        if (bus.branch_taken) begin
          fc_d = FC_RELOAD;
        end else if (fc_q <= 4'd1) begin
          state_d = RUN;
          fc_d    = '0;
        end else begin
          fc_d = fc_q - 4'd1;
        end
      end
      ev_branch: begin
        ifid_flush = 1'b1;
        csel       = 1'b0;
        if (MULTI) begin
          state_d = FLUSH;
          fc_d    = FC_RELOAD;
        end
      end
      ev_stall: begin
        pc_we   = 1'b0;
        ifid_we = 1'b0;
        csel    = 1'b0;
      end
      default: ;
    endcase
  end

  // Controls are held inactive for the whole time reset is asserted
  assign bus.pc_write_en    = reset_n && pc_we;
  assign bus.if_id_write_en = reset_n && ifid_we;
  assign bus.if_id_flush    = reset_n && ifid_flush;
  assign bus.ctr_sel        = reset_n && csel;
  assign bus.id_ex_write_en = reset_n && idex_we;
  assign bus.ex_mem_hold    = reset_n && hold;
  assign bus.flush_busy     = reset_n && fbusy;

  function automatic logic [CNT_WIDTH-1:0] bump(
    input logic [CNT_WIDTH-1:0] c,
    input logic                 inc,
    input logic                 clr
  );
    if (clr)                        return '0;
    else if (inc && (c != CNT_MAX)) return c + 1'b1;
    else                            return c;
  endfunction

  always_comb begin
    stall_cnt_d  = bump(stall_cnt_q, ev_stall, bus.cnt_clr);
    flush_cnt_d  = bump(flush_cnt_q, ev_flush || ev_branch,
                        bus.cnt_clr);
    freeze_cnt_d = bump(freeze_cnt_q, ev_freeze, bus.cnt_clr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RUN;
      fc_q         <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      fc_q         <= fc_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;
  assign bus.freeze_cnt = freeze_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: control vectors go through a
// scoreboard queue, counters are checked against bench-held values.
module tb_hazard_ctrl;

  localparam int RAW = 5;
  localparam int CW  = 4;

  // {pc_we, ifid_we, ifid_flush, ctr_sel, idex_we, hold, flush_busy}
  localparam logic [6:0] E_RST    = 7'b0000000;
  localparam logic [6:0] E_IDLE   = 7'b1101100;
  localparam logic [6:0] E_STALL  = 7'b0000100;
  localparam logic [6:0] E_BRANCH = 7'b1110100;
  localparam logic [6:0] E_FLUSH  = 7'b1110101;
  localparam logic [6:0] E_FREEZE = 7'b0001010;

  logic clk = 1'b0;
  logic reset_n;

  int total = 0;
  int bad   = 0;

  logic [6:0] sb_q[$];

  hazard_ctrl_if #(.REG_ADDR_WIDTH(RAW), .CNT_WIDTH(CW)) hif ();

  hazard_ctrl #(
    .REG_ADDR_WIDTH(RAW),
    .FLUSH_CYCLES  (2),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (hif)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ctl_now();
    return {hif.pc_write_en, hif.if_id_write_en, hif.if_id_flush,
            hif.ctr_sel, hif.id_ex_write_en, hif.ex_mem_hold,
            hif.flush_busy};
  endfunction

  // Push the expected vector, settle, then pop and compare
  task automatic chk_ctl(input string tag, input logic [6:0] exp);
    logic [6:0] e;
    logic [6:0] got;
    sb_q.push_back(exp);
    #2;
    got = ctl_now();
    e = sb_q.pop_front();
    total++;
    assert (got === e) else begin
      bad++;
      $error("FAIL %s ctl got=%b exp=%b", tag, got, e);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [CW-1:0] got,
                         input logic [CW-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cnt got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic quiet();
    hif.id_rs1          = '0;
    hif.id_rs2          = '0;
    hif.id_uses_rs1     = 1'b0;
    hif.id_uses_rs2     = 1'b0;
    hif.ex_rd           = '0;
    hif.ex_is_load      = 1'b0;
    hif.ex_reg_write_en = 1'b0;
    hif.branch_taken    = 1'b0;
    hif.dmem_busy       = 1'b0;
    hif.cnt_clr         = 1'b0;
  endtask

  task automatic load_use(input logic [RAW-1:0] rd);
    hif.ex_is_load      = 1'b1;
    hif.ex_reg_write_en = 1'b1;
    hif.ex_rd           = rd;
    hif.id_rs2          = rd;
    hif.id_uses_rs2     = 1'b1;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    quiet();
    reset_n = 1'b0;
    nxt();
    chk_ctl("reset_forced", E_RST);
    chk_cnt("reset_stall", hif.stall_cnt, 4'd0);
    nxt();
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      chk_ctl("idle", E_IDLE);
      nxt();
    end
    chk_cnt("idle_stall", hif.stall_cnt, 4'd0);
    chk_cnt("idle_flush", hif.flush_cnt, 4'd0);
    chk_cnt("idle_freeze", hif.freeze_cnt, 4'd0);

    load_use(5'd5);
    chk_ctl("lu_rs2", E_STALL);
    nxt();
    quiet();
    chk_ctl("lu_bubble", E_IDLE);
    chk_cnt("lu_cnt", hif.stall_cnt, 4'd1);
    nxt();

    load_use(5'd0);
    chk_ctl("lu_x0", E_IDLE);
    nxt();
    chk_cnt("lu_x0_cnt", hif.stall_cnt, 4'd1);
    quiet();
    hif.ex_is_load      = 1'b1;
    hif.ex_reg_write_en = 1'b1;
    hif.ex_rd           = 5'd7;
    hif.id_rs1          = 5'd7;
    chk_ctl("lu_rs1_unused", E_IDLE);
    hif.id_uses_rs1 = 1'b1;
    chk_ctl("lu_rs1", E_STALL);
    nxt();
    quiet();
    chk_cnt("lu_rs1_cnt", hif.stall_cnt, 4'd2);

    hif.branch_taken = 1'b1;
    chk_ctl("br_first", E_BRANCH);
    nxt();
    hif.branch_taken = 1'b0;
    load_use(5'd3);
    chk_ctl("br_flush_lu_supp", E_FLUSH);
    nxt();
    quiet();
    chk_ctl("br_done", E_IDLE);
    chk_cnt("br_flush_cnt", hif.flush_cnt, 4'd2);
    chk_cnt("br_stall_cnt", hif.stall_cnt, 4'd2);
    nxt();

    hif.dmem_busy    = 1'b1;
    hif.branch_taken = 1'b1;
    load_use(5'd9);
    for (int i = 0; i < 3; i++) begin
      chk_ctl("frz", E_FREEZE);
      nxt();
    end
    chk_cnt("frz_cnt", hif.freeze_cnt, 4'd3);
    chk_cnt("frz_flush_cnt", hif.flush_cnt, 4'd2);
    hif.dmem_busy = 1'b0;
    chk_ctl("frz_rel_branch", E_BRANCH);
    nxt();
    hif.branch_taken = 1'b0;
    chk_ctl("frz_rel_flush", E_FLUSH);
    nxt();
    quiet();
    chk_ctl("frz_done", E_IDLE);
    chk_cnt("frz_stall_cnt", hif.stall_cnt, 4'd2);
    chk_cnt("frz_flush_cnt2", hif.flush_cnt, 4'd4);
    nxt();

    hif.branch_taken = 1'b1;
    chk_ctl("rl_branch", E_BRANCH);
    nxt();
    chk_ctl("rl_reload", E_FLUSH);
    nxt();
    hif.branch_taken = 1'b0;
    chk_ctl("rl_last", E_FLUSH);
    nxt();
    chk_ctl("rl_done", E_IDLE);
    chk_cnt("rl_flush_cnt", hif.flush_cnt, 4'd7);
    nxt();

    load_use(5'd12);
    for (int i = 0; i < 20; i++) begin
      chk_ctl("sat_stall", E_STALL);
      nxt();
    end
    chk_cnt("sat_cnt", hif.stall_cnt, 4'd15);
    hif.cnt_clr = 1'b1;
    chk_ctl("clr_stall", E_STALL);
    nxt();
    quiet();
    chk_cnt("clr_stall_cnt", hif.stall_cnt, 4'd0);
    chk_cnt("clr_flush_cnt", hif.flush_cnt, 4'd0);
    chk_cnt("clr_freeze_cnt", hif.freeze_cnt, 4'd0);

    hif.branch_taken = 1'b1;
    chk_ctl("mr_branch", E_BRANCH);
    nxt();
    hif.branch_taken = 1'b0;
    chk_ctl("mr_flush", E_FLUSH);
    reset_n = 1'b0;
    chk_ctl("mr_reset", E_RST);
    chk_cnt("mr_flush_cnt", hif.flush_cnt, 4'd0);
    nxt();
    reset_n = 1'b1;
    chk_ctl("mr_after", E_IDLE);
    nxt();
    chk_ctl("mr_after2", E_IDLE);
    chk_cnt("mr_cnt", hif.flush_cnt, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Producer side of the ID/EX pipeline register's control interface. Generates `ctr_sel` (1 = pass decoded controls, 0 = insert bubble) together with the PC, IF/ID, ID/EX and EX/MEM write/flush controls.
- Detects load-use hazards and redirects on taken branches, with a multi-cycle flush sequence.
- Freezes the whole pipeline while data memory is busy.
- Keeps saturating performance counters for stalls, flushes and freezes.
- Sits in the ID stage, next to the register file and the control decoder.

Parameters:
- REG_ADDR_WIDTH, 5, register-address width (`REG_ADDR_WIDTH).
- FLUSH_CYCLES, 2, number of cycles IF/ID is flushed after a taken branch; legal range 1..15.
- CNT_WIDTH, 16, width of each performance counter.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset
- id_rs1  in  REG_ADDR_WIDTH  rs1 of the instruction in IF/ID
- id_rs2  in  REG_ADDR_WIDTH  rs2 of the instruction in IF/ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_rd  in  REG_ADDR_WIDTH  ID_EX_rd
- ex_is_load  in  1  instruction in EX is a load
- ex_reg_write_en  in  1  ID_EX_reg_write_en
- branch_taken  in  1  EX resolved a taken branch or jump
- dmem_busy  in  1  data memory not ready
- cnt_clr  in  1  synchronous clear of all counters
- pc_write_en  out  1  PC update enable
- if_id_write_en  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID load NOP
- ctr_sel  out  1  ID/EX control select
- id_ex_write_en  out  1  ID/EX load enable
- ex_mem_hold  out  1  EX/MEM and MEM/WB hold
- flush_busy  out  1  FSM is in FLUSH
- stall_cnt  out  CNT_WIDTH  load-use bubble cycles
- flush_cnt  out  CNT_WIDTH  cycles with if_id_flush=1
- freeze_cnt  out  CNT_WIDTH  cycles with dmem_busy freeze

Behaviour:
- Clock and reset: clk, rising edge; reset_n asynchronous, active-low.
- Reset: state=RUN, flush counter fc=0, all performance counters 0.
  - While reset_n=0, pc_write_en, if_id_write_en, id_ex_write_en, ctr_sel, if_id_flush, ex_mem_hold and flush_busy are all forced to 0.
- Output timing: outputs are combinational from state, fc and the current inputs; state, fc and counters are registered. Zero-cycle latency from hazard to control.
- Default outputs in RUN with no event: pc_write_en=1, if_id_write_en=1, id_ex_write_en=1, ctr_sel=1, if_id_flush=0, ex_mem_hold=0.
- Priority, highest first: freeze, then branch, then load-use.
- Freeze (any state, dmem_busy=1):
  - pc_write_en=0, if_id_write_en=0, id_ex_write_en=0, ex_mem_hold=1, ctr_sel=1, if_id_flush=0.
  - State and fc hold; branch_taken is ignored, since EX is frozen and the branch re-presents after release.
  - freeze_cnt increments.
- Branch, RUN state:
  - Condition: branch_taken=1 and dmem_busy=0.
  - Outputs: pc_write_en=1, if_id_write_en=1, if_id_flush=1, ctr_sel=0; flush_cnt increments.
  - If FLUSH_CYCLES>1: next state FLUSH, fc=FLUSH_CYCLES-1. Otherwise stay in RUN.
- FLUSH state, dmem_busy=0:
  - Outputs: if_id_flush=1, ctr_sel=0, pc_write_en=1, if_id_write_en=1, flush_busy=1; flush_cnt increments.
  - Load-use detection is suppressed.
  - fc decrements each cycle; when fc==1, next state is RUN.
  - branch_taken=1 in FLUSH reloads fc=FLUSH_CYCLES-1 and keeps the FSM in FLUSH.
- Load-use, RUN state only:
  - Hazard condition: ex_is_load & ex_reg_write_en & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - Active only when dmem_busy=0 and branch_taken=0.
  - Outputs: pc_write_en=0, if_id_write_en=0, ctr_sel=0, id_ex_write_en=1 (a bubble enters ID/EX); stall_cnt increments.
  - Exactly one bubble per load: in the next cycle EX holds the bubble, so the condition clears by itself.
- x0: ex_rd=0 never causes a hazard.
- Counters:
  - Saturate at all-ones.
  - cnt_clr=1 zeroes all counters on the next edge and takes precedence over any increment in the same cycle.
- Reset mid-FLUSH: returns the FSM to RUN immediately, and no flush continues after release.

Test Plan:
- Reset release, no events: all enables=1, ctr_sel=1, counters stay 0 for 10 cycles.
- Load-use hazard:
  - Stimulus: ex_is_load=1, ex_reg_write_en=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 for 1 cycle.
  - Response: pc_write_en=0, if_id_write_en=0, ctr_sel=0 that cycle; stall_cnt=1.
  - Same stimulus with ex_rd=0 gives no stall.
- Branch with FLUSH_CYCLES=2:
  - Stimulus: branch_taken pulse.
  - Response: if_id_flush=1 and ctr_sel=0 for exactly 2 cycles, flush_busy=1 in the 2nd, then RUN; flush_cnt=2.
- Simultaneous events:
  - dmem_busy=1 for 3 cycles concurrent with branch_taken=1 and a load-use match: freeze outputs only, freeze_cnt=3.
  - On release, the branch is honoured and load-use is ignored.
- Counter saturation and clear:
  - Stimulus: CNT_WIDTH=4, 20 load-use events.
  - Response: stall_cnt saturates at 15; cnt_clr coincident with an event yields 0.
- Mid-flush reset: reset_n low during FLUSH with fc=1 → after release state=RUN, if_id_flush=0, counters=0.
